// File: rtl/scr_pkg.sv
// scr_pkg: shared types and constants for the frame-level additive scrambler.
`default_nettype none

package scr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scr_state_e;

   // Feedback taps: bits 0, 1, 2 and 7.
   localparam logic [7:0] LFSR_TAPS    = 8'h87;
   localparam logic [7:0] SEED_DEFAULT = 8'h01;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/scr_lfsr8.sv
// scr_lfsr8: 8-bit keystream LFSR with seed load (zero seed forced to SEED_DEFAULT).
`default_nettype none

module scr_lfsr8
   import scr_pkg::*;
(
   input  logic       clk1,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       step,
   output logic [7:0] state
);

   logic [7:0] state_q;

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state_q <= SEED_DEFAULT;
      end else if (load) begin
         // An all-zero state would lock the LFSR, so it is never loaded.
         state_q <= (load_val == 8'h00) ? SEED_DEFAULT : load_val;
      end else if (step) begin
         state_q <= lfsr_next(state_q);
      end
   end

   assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/scrambler_frame_ctrl.sv
// scrambler_frame_ctrl: frame sequencer that XORs a byte stream with an LFSR keystream,
// counts bytes against the programmed length and flags last byte / frame completion.
`default_nettype none

module scrambler_frame_ctrl
   import scr_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       seed,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             scramble_en,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   scr_state_e       state_q;
   logic [LEN_W-1:0] remaining_q;
   logic             en_q;
   logic             out_valid_q;
   logic [7:0]       out_data_q;
   logic             out_last_q;
   logic             done_q;

   logic [7:0]       lfsr_state;
   logic [7:0]       scr_byte_d;
   logic             in_xfer;
   logic             out_xfer;
   logic             lfsr_load;

   assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign in_xfer    = in_valid && in_ready;
   assign out_xfer   = out_valid_q && out_ready;
   assign lfsr_load  = (state_q == ST_IDLE) && start;
   assign scr_byte_d = in_data ^ (en_q ? lfsr_state : 8'h00);

   scr_lfsr8 u_lfsr (
      .clk1     (clk1),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (seed),
      .step     (in_xfer),
      .state    (lfsr_state)
   );

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         en_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  remaining_q <= frame_len;
                  en_q        <= scramble_en;
                  if (frame_len == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state_q     <= ST_DONE;
                  done_q      <= 1'b1;
               end else begin
                  // Drain and reload may coincide; the load below wins.
                  if (out_xfer) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end
                  if (in_xfer) begin
                     out_data_q  <= scr_byte_d;
                     out_valid_q <= 1'b1;
                     out_last_q  <= (remaining_q == LEN_W'(1));
                     remaining_q <= remaining_q - LEN_W'(1);
                     if (remaining_q == LEN_W'(1)) begin
                        state_q <= ST_DRAIN;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (abort || out_xfer) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state_q     <= ST_DONE;
                  done_q      <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_scrambler_frame_ctrl.sv
// tb_scrambler_frame_ctrl: directed and randomized frames checked against a keystream/scoreboard model.
`default_nettype none

module tb_scrambler_frame_ctrl;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  seed;
   logic [15:0] frame_len;
   logic        scramble_en;
   logic        abort;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  tb_data [0:15];

   always #5 clk1 = ~clk1;

   scrambler_frame_ctrl #(.LEN_W(16)) dut (
      .clk1        (clk1),
      .rst         (rst),
      .start       (start),
      .seed        (seed),
      .frame_len   (frame_len),
      .scramble_en (scramble_en),
      .abort       (abort),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Keystream successor: shift left, feedback is parity of bits 0,1,2,7.
   function automatic logic [7:0] ks_step(input logic [7:0] s);
      return {s[6:0], s[0] ^ s[1] ^ s[2] ^ s[7]};
   endfunction

   // mode 0: always ready/valid; 1: random handshakes; 2: 3-cycle output stall after first byte.
   task automatic run_frame(input logic [7:0] sd, input int len, input logic en, input int mode);
      logic [7:0] exp_b [0:15];
      logic [7:0] s;
      logic [7:0] prev_data;
      logic       prev_hold;
      logic       exp_rdy;
      int         idx_in, idx_out, cyc, stall_cnt;
      s = (sd == 8'h00) ? 8'h01 : sd;
      for (int k = 0; k < len; k++) begin
         exp_b[k] = tb_data[k] ^ (en ? s : 8'h00);
         s = ks_step(s);
      end
      @(negedge clk1);
      start = 1'b1; seed = sd; frame_len = len[15:0]; scramble_en = en;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk1);
      start = 1'b0;
      #1;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
      idx_in = 0; idx_out = 0; cyc = 0; stall_cnt = 0; prev_hold = 1'b0; prev_data = 8'h00;
      while (idx_out < len && cyc < 500) begin
         in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = (idx_in < len) ? tb_data[idx_in] : 8'($urandom);
         if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
         else if (mode == 2 && idx_out == 0 && out_valid && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
         end else out_ready = 1'b1;
         #1;
         if (prev_hold) chk("held_data", {24'd0, out_data}, {24'd0, prev_data});
         exp_rdy = (idx_in < len) && (!out_valid || out_ready);
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         if (out_valid && out_ready) begin
            chk("out_data", {24'd0, out_data}, {24'd0, exp_b[idx_out]});
            chk("out_last", {31'd0, out_last}, (idx_out == len - 1) ? 32'd1 : 32'd0);
            idx_out++;
         end
         if (in_valid && in_ready) idx_in++;
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         cyc++;
         @(negedge clk1);
      end
      in_valid = 1'b0;
      chk("frame_complete", idx_out, len);
      if (mode == 0) chk("throughput_cycles", cyc, len + 1);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("out_valid_at_done", {31'd0, out_valid}, 32'd0);
      @(negedge clk1);
      #1;
      chk("done_cleared", {31'd0, done}, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_data"},  {24'd0, out_data}, 32'd0);
      chk({tag, "_out_last"},  {31'd0, out_last}, 32'd0);
      chk({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
      chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
      chk({tag, "_done"},      {31'd0, done}, 32'd0);
   endtask

   initial begin
      int len;
      rst = 1'b0; start = 1'b0; seed = 8'h00; frame_len = 16'd0; scramble_en = 1'b0;
      abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (2) @(negedge clk1);
      #1;
      check_reset_values("reset");
      @(negedge clk1);
      rst = 1'b1;

      for (int k = 0; k < 16; k++) tb_data[k] = 8'h00;
      run_frame(8'h01, 5, 1'b1, 0);
      for (int k = 0; k < 16; k++) tb_data[k] = 8'hFF;
      run_frame(8'h01, 5, 1'b1, 0);
      for (int k = 0; k < 16; k++) tb_data[k] = 8'h00;
      run_frame(8'h00, 2, 1'b1, 0);
      tb_data[0] = 8'hAA; tb_data[1] = 8'hBB; tb_data[2] = 8'hCC;
      run_frame(8'h5A, 3, 1'b0, 0);
      for (int k = 0; k < 16; k++) tb_data[k] = 8'h00;
      run_frame(8'h01, 4, 1'b1, 2);

      // Abort after two of six bytes.
      @(negedge clk1);
      start = 1'b1; seed = 8'h01; frame_len = 16'd6; scramble_en = 1'b1; out_ready = 1'b1;
      @(negedge clk1);
      start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
      @(negedge clk1);
      #1;
      chk("abort_b0_valid", {31'd0, out_valid}, 32'd1);
      chk("abort_b0_data", {24'd0, out_data}, 32'h01);
      @(negedge clk1);
      #1;
      chk("abort_b1_data", {24'd0, out_data}, 32'h03);
      abort = 1'b1; in_valid = 1'b0;
      @(negedge clk1);
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      abort = 1'b0;
      @(negedge clk1);
      #1;
      chk("abort_done_cleared", {31'd0, done}, 32'd0);
      chk("abort_idle_in_ready", {31'd0, in_ready}, 32'd0);
      run_frame(8'h01, 5, 1'b1, 0);

      // Zero-length frame.
      @(negedge clk1);
      start = 1'b1; seed = 8'h42; frame_len = 16'd0;
      @(negedge clk1);
      start = 1'b0;
      #1;
      chk("zlen_done", {31'd0, done}, 32'd1);
      chk("zlen_out_valid", {31'd0, out_valid}, 32'd0);
      chk("zlen_busy", {31'd0, busy}, 32'd0);
      @(negedge clk1);
      #1;
      chk("zlen_done_cleared", {31'd0, done}, 32'd0);

      repeat (8) begin
         len = $urandom_range(1, 12);
         for (int k = 0; k < 16; k++) tb_data[k] = 8'($urandom);
         run_frame(8'($urandom), len, 1'($urandom_range(0, 1)), 1);
      end

      // Reset in the middle of a frame.
      @(negedge clk1);
      start = 1'b1; seed = 8'h33; frame_len = 16'd8; scramble_en = 1'b1;
      @(negedge clk1);
      start = 1'b0; in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b0;
      repeat (3) @(negedge clk1);
      #1;
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check_reset_values("midreset");
      @(negedge clk1);
      rst = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 16; k++) tb_data[k] = 8'h00;
      run_frame(8'h01, 5, 1'b1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/scrambler_frame_ctrl.md
# scrambler_frame_ctrl

Frame-level sequencer for the 8-bit additive scrambler. It loads a seed into a private 8-bit LFSR at frame start and XORs each accepted data byte with the current LFSR state. The LFSR advances once per delivered byte. It counts bytes against a programmed frame length and flags the last byte and frame completion. It sits between the byte-stream source and the serializer, and it owns all sequencing of the keystream generator.

## Interface
Parameters:
- LEN_W, 16: width of the frame-length field; maximum frame is 2^LEN_W − 1 bytes.

Ports:
- clk1  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; accepted only in IDLE.
- seed  input  8  LFSR seed, sampled with start; 0x00 is replaced by 0x01.
- frame_len  input  LEN_W  byte count, sampled with start.
- scramble_en  input  1  sampled with start; 0 = bypass (data passes unmodified, LFSR still advances).
- abort  input  1  level; ends the current frame at the next edge.
- in_valid / in_ready  input / output  1  upstream handshake.
- in_data  input  8  plaintext byte.
- out_valid / out_ready  output / input  1  downstream handshake.
- out_data  output  8  scrambled byte.
- out_last  output  1  high with the final byte of the frame.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - Capture seed (0x00→0x01) into the LFSR, frame_len into remaining, and scramble_en.
  - Go to RUN. If frame_len==0, go directly to DONE.
- RUN:
  - in_ready = (!out_valid || out_ready).
  - On an input transfer: out_data ← in_data ^ (en ? lfsr : 0x00); out_valid←1; remaining−1; LFSR steps.
  - out_last ← (remaining==1).
  - When the last byte is captured, go to DRAIN.
- LFSR step: next = {s[6:0], s[0]^s[1]^s[2]^s[7]}. It steps only on an input transfer.
- DRAIN: in_ready=0. When the output transfer completes (out_valid && out_ready), go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort (RUN or DRAIN):
  - Next edge: out_valid←0, out_last←0, go to DONE. The pending output byte is discarded.
  - abort is ignored in IDLE and DONE.
- start outside IDLE is ignored.
- Output register rules:
  - It holds its value while out_valid && !out_ready.
  - A simultaneous output drain and input load in the same cycle is legal and gives full throughput.

## Timing
- Reset values: out_valid=0, out_data=0x00, out_last=0, in_ready=0, busy=0, done=0; LFSR=0x01; state IDLE.
- Latency: input transfer at edge N → out_valid at N+1. Throughput is 1 byte/cycle when out_ready stays high.
- start at edge N → busy=1 and in_ready=1 from N+1.
- Last output transfer at edge M → done=1 during cycle M+1, busy=0 from M+1, IDLE at M+2.
- frame_len==0: done pulses in the cycle after start; no bytes move.
- in_ready is combinational from out_valid/out_ready and the state. out_* and done are registered.
- Asserting rst mid-frame returns to the reset values immediately. The partial frame is lost.

## Structure
- Shared package scr_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the LFSR tap constant (bits 0,1,2,7);
  - SEED_DEFAULT=8'h01.
- Sub-module scr_lfsr8 contains only the LFSR, with ports clk1, rst, load, load_val, step, state.
- The FSM, counter and output register live in the top.

## Test plan
- Seed 0x01, frame_len 5, en=1, data 0x00 ×5, out_ready=1 → out_data 01,03,06,0C,19 on consecutive cycles; out_last only on 0x19; done one cycle after.
- Same setup with data 0xFF ×5 → FE,FC,F9,F3,E6.
- Seed 0x00, frame_len 2, data 0x00 → 01,03 (zero-seed substitution).
- en=0, frame_len 3, data AA,BB,CC → AA,BB,CC out unchanged.
- Stall check:
  - frame_len 4, out_ready low 3 cycles after the first byte → in_ready low, out_data held at the first byte.
  - Resume → remaining bytes 03,06,0C (data 0x00); no loss or duplication.
- abort:
  - Assert abort after 2 of 6 bytes → out_valid 0 next edge, done pulse, IDLE.
  - A new start with seed 0x01 → keystream restarts at 01.
- frame_len 0 → done pulse the cycle after start, no out_valid.
- Reset asserted mid-frame → reset values immediately.
